// File: rtl/rxd_frame_decoder.sv
// Receive-side decoder for the 14-byte UART telemetry frame: 0xFF preamble, 10 payload bytes, range check, atomic output update.
// Optional build macro RXD_FRAME_CHECKSUM_EN appends an XOR checksum byte after the payload.
module rxd_frame_decoder #(
  parameter int SYNC_LEN       = 4,
  parameter int PAYLOAD_LEN    = 10,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  output logic [9:0] xpos_tank_enemy,
  output logic [9:0] ypos_tank_enemy,
  output logic [9:0] xpos_bullet_enemy,
  output logic [9:0] ypos_bullet_enemy,
  output logic [6:0] flags_enemy,
  output logic [7:0] hp_enemy,
  output logic       frame_valid,
  output logic       sync_locked,
  output logic [7:0] err_count
);

  typedef enum logic [1:0] {HUNT, PAYLOAD, SYNC_CHECK} state_t;

`ifdef RXD_FRAME_CHECKSUM_EN
  localparam int LAST_IDX = PAYLOAD_LEN;
`else
  localparam int LAST_IDX = PAYLOAD_LEN - 1;
`endif
  localparam int IDX_W  = $clog2(PAYLOAD_LEN + 2);
  localparam int SYNC_W = $clog2(SYNC_LEN + 1);
  localparam int TMO_W  = $clog2(TIMEOUT_CYCLES + 1);

  state_t            state_reg;
  logic [SYNC_W-1:0] sync_cnt_reg;
  logic [IDX_W-1:0]  idx_reg;
  logic [7:0]        shadow_reg [0:PAYLOAD_LEN-1];
  logic [TMO_W-1:0]  tmo_cnt_reg;
  logic              timeout;
  logic              range_bad;
  logic              last_byte;
  logic              frame_ok;
  logic [7:0]        hp_byte;
  logic [7:0]        err_inc;

  // Inter-byte idle timer; saturates so a long idle raises timeout continuously.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt_reg <= '0;
    end else if (rx_done) begin
      tmo_cnt_reg <= '0;
    end else if (tmo_cnt_reg != TMO_W'(TIMEOUT_CYCLES)) begin
      tmo_cnt_reg <= tmo_cnt_reg + TMO_W'(1);
    end
  end

  assign timeout   = !rx_done && (tmo_cnt_reg == TMO_W'(TIMEOUT_CYCLES));
  assign range_bad = ((idx_reg < IDX_W'(8)) && idx_reg[0] && (rx_data > 8'h03)) ||
                     ((idx_reg == IDX_W'(8)) && rx_data[7]);
  assign last_byte = (idx_reg == IDX_W'(LAST_IDX));
  assign err_inc   = (err_count == 8'hFF) ? 8'hFF : err_count + 8'd1;

`ifdef RXD_FRAME_CHECKSUM_EN
  logic [7:0] xor_reg;
  assign frame_ok = (rx_data == xor_reg);
  assign hp_byte  = shadow_reg[9];
`else
  assign frame_ok = 1'b1;
  assign hp_byte  = rx_data;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg         <= HUNT;
      sync_cnt_reg      <= '0;
      idx_reg           <= '0;
      xpos_tank_enemy   <= '0;
      ypos_tank_enemy   <= '0;
      xpos_bullet_enemy <= '0;
      ypos_bullet_enemy <= '0;
      flags_enemy       <= '0;
      hp_enemy          <= '0;
      frame_valid       <= 1'b0;
      sync_locked       <= 1'b0;
      err_count         <= '0;
`ifdef RXD_FRAME_CHECKSUM_EN
      xor_reg           <= '0;
`endif
      for (int i = 0; i < PAYLOAD_LEN; i++) shadow_reg[i] <= '0;
    end else begin
      frame_valid <= 1'b0;
      if (rx_done) begin
        unique case (state_reg)
          HUNT: begin
            if (sync_cnt_reg == SYNC_W'(SYNC_LEN)) begin
              // Byte after a full preamble is payload byte 0, even if it is 0xFF.
              shadow_reg[0] <= rx_data;
              idx_reg       <= IDX_W'(1);
              sync_cnt_reg  <= '0;
              state_reg     <= PAYLOAD;
`ifdef RXD_FRAME_CHECKSUM_EN
              xor_reg       <= rx_data;
`endif
            end else if (rx_data == 8'hFF) begin
              sync_cnt_reg <= sync_cnt_reg + SYNC_W'(1);
            end else begin
              sync_cnt_reg <= '0;
            end
          end
          PAYLOAD: begin
            if (range_bad || (last_byte && !frame_ok)) begin
              err_count    <= err_inc;
              sync_locked  <= 1'b0;
              sync_cnt_reg <= '0;
              state_reg    <= HUNT;
            end else if (last_byte) begin
              // High bytes are range-checked to <= 3, so truncation drops only zeros.
              xpos_tank_enemy   <= 10'({shadow_reg[1], shadow_reg[0]});
              ypos_tank_enemy   <= 10'({shadow_reg[3], shadow_reg[2]});
              xpos_bullet_enemy <= 10'({shadow_reg[5], shadow_reg[4]});
              ypos_bullet_enemy <= 10'({shadow_reg[7], shadow_reg[6]});
              flags_enemy       <= 7'(shadow_reg[8]);
              hp_enemy          <= hp_byte;
              frame_valid       <= 1'b1;
              sync_locked       <= 1'b1;
              sync_cnt_reg      <= '0;
              state_reg         <= SYNC_CHECK;
            end else begin
              for (int i = 0; i < PAYLOAD_LEN; i++) begin
                if (idx_reg == IDX_W'(i)) shadow_reg[i] <= rx_data;
              end
              idx_reg <= idx_reg + IDX_W'(1);
`ifdef RXD_FRAME_CHECKSUM_EN
              xor_reg <= xor_reg ^ rx_data;
`endif
            end
          end
          SYNC_CHECK: begin
            if (rx_data != 8'hFF) begin
              err_count    <= err_inc;
              sync_locked  <= 1'b0;
              sync_cnt_reg <= '0;
              state_reg    <= HUNT;
            end else if (sync_cnt_reg == SYNC_W'(SYNC_LEN - 1)) begin
              idx_reg      <= '0;
              sync_cnt_reg <= '0;
              state_reg    <= PAYLOAD;
`ifdef RXD_FRAME_CHECKSUM_EN
              xor_reg      <= '0;
`endif
            end else begin
              sync_cnt_reg <= sync_cnt_reg + SYNC_W'(1);
            end
          end
          default: state_reg <= HUNT;
        endcase
      end else if (timeout) begin
        if (state_reg == HUNT) begin
          sync_cnt_reg <= '0;
        end else begin
          err_count    <= err_inc;
          sync_locked  <= 1'b0;
          sync_cnt_reg <= '0;
          state_reg    <= HUNT;
        end
      end
    end
  end

endmodule

// File: tb/tb_rxd_frame_decoder.sv
// Directed testbench for rxd_frame_decoder: hand-built frames, error paths, timeout, reset and error-count saturation.
module tb_rxd_frame_decoder;

  localparam int TMO = 50;
`ifdef RXD_FRAME_CHECKSUM_EN
  localparam int FLEN = 11;
`else
  localparam int FLEN = 10;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_done;
  logic [9:0] xpos_tank_enemy, ypos_tank_enemy, xpos_bullet_enemy, ypos_bullet_enemy;
  logic [6:0] flags_enemy;
  logic [7:0] hp_enemy;
  logic       frame_valid, sync_locked;
  logic [7:0] err_count;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] frm [0:10];

  rxd_frame_decoder #(
    .SYNC_LEN       (4),
    .PAYLOAD_LEN    (10),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .rx_data           (rx_data),
    .rx_done           (rx_done),
    .xpos_tank_enemy   (xpos_tank_enemy),
    .ypos_tank_enemy   (ypos_tank_enemy),
    .xpos_bullet_enemy (xpos_bullet_enemy),
    .ypos_bullet_enemy (ypos_bullet_enemy),
    .flags_enemy       (flags_enemy),
    .hp_enemy          (hp_enemy),
    .frame_valid       (frame_valid),
    .sync_locked       (sync_locked),
    .err_count         (err_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic load_frame(input logic [9:0] x, input logic [9:0] y, input logic [9:0] bx,
                            input logic [9:0] by, input logic [6:0] fl, input logic [7:0] hp);
    frm[0] = x[7:0];  frm[1] = {6'b0, x[9:8]};
    frm[2] = y[7:0];  frm[3] = {6'b0, y[9:8]};
    frm[4] = bx[7:0]; frm[5] = {6'b0, bx[9:8]};
    frm[6] = by[7:0]; frm[7] = {6'b0, by[9:8]};
    frm[8] = {1'b0, fl};
    frm[9] = hp;
    frm[10] = '0;
    for (int i = 0; i < 10; i++) frm[10] = frm[10] ^ frm[i];
  endtask

  // Byte is presented at a falling edge and sampled on the next rising edge;
  // returns at the falling edge just after that rising edge.
  task automatic send_byte(input logic [7:0] b);
    repeat (2) @(negedge clk);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
    rx_data = 8'h00;
  endtask

  task automatic send_pre();
    repeat (4) send_byte(8'hFF);
  endtask

  task automatic send_frm(input int from, input int upto);
    for (int i = from; i < upto; i++) send_byte(frm[i]);
  endtask

  task automatic check_outs(input string tag, input logic [9:0] x, input logic [9:0] y,
                            input logic [9:0] bx, input logic [9:0] by, input logic [6:0] fl,
                            input logic [7:0] hp, input logic vld, input logic lock,
                            input logic [7:0] err);
    check({tag, ".x"},    32'(xpos_tank_enemy),   32'(x));
    check({tag, ".y"},    32'(ypos_tank_enemy),   32'(y));
    check({tag, ".bx"},   32'(xpos_bullet_enemy), 32'(bx));
    check({tag, ".by"},   32'(ypos_bullet_enemy), 32'(by));
    check({tag, ".fl"},   32'(flags_enemy),       32'(fl));
    check({tag, ".hp"},   32'(hp_enemy),          32'(hp));
    check({tag, ".vld"},  32'(frame_valid),       32'(vld));
    check({tag, ".lock"}, 32'(sync_locked),       32'(lock));
    check({tag, ".err"},  32'(err_count),         32'(err));
    $display("%s: x=%03h y=%03h bx=%03h by=%03h fl=%02h hp=%02h vld=%0b lock=%0b err=%0d",
             tag, xpos_tank_enemy, ypos_tank_enemy, xpos_bullet_enemy, ypos_bullet_enemy,
             flags_enemy, hp_enemy, frame_valid, sync_locked, err_count);
  endtask

  initial begin
    rst = 1'b1; rx_data = 8'h00; rx_done = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_outs("reset", 10'h0, 10'h0, 10'h0, 10'h0, 7'h0, 8'h0, 1'b0, 1'b0, 8'd0);

    // Basic frame: 2C 01 64 00 10 02 20 03 55 C8
    load_frame(10'h12C, 10'h064, 10'h210, 10'h320, 7'h55, 8'hC8);
    send_pre(); send_frm(0, FLEN);
    check_outs("frame1", 10'h12C, 10'h064, 10'h210, 10'h320, 7'h55, 8'hC8, 1'b1, 1'b1, 8'd0);
    @(negedge clk);
    check("frame1.pulse_end", 32'(frame_valid), 32'd0);

    // HP=0xFF directly followed by the preamble, then X lo=0xFF
    load_frame(10'h0AB, 10'h1CD, 10'h3FF, 10'h000, 7'h7F, 8'hFF);
    send_pre(); send_frm(0, FLEN);
    check_outs("frameA", 10'h0AB, 10'h1CD, 10'h3FF, 10'h000, 7'h7F, 8'hFF, 1'b1, 1'b1, 8'd0);
    load_frame(10'h2FF, 10'h3C3, 10'h155, 10'h2AA, 7'h01, 8'h11);
    send_pre(); send_frm(0, FLEN);
    check_outs("frameB", 10'h2FF, 10'h3C3, 10'h155, 10'h2AA, 7'h01, 8'h11, 1'b1, 1'b1, 8'd0);

    // X hi out of range while locked
    send_pre(); send_byte(8'h2C); send_byte(8'h04);
    check_outs("xhi_bad", 10'h2FF, 10'h3C3, 10'h155, 10'h2AA, 7'h01, 8'h11, 1'b0, 1'b0, 8'd1);
    load_frame(10'h001, 10'h002, 10'h003, 10'h004, 7'h2A, 8'h80);
    send_pre(); send_frm(0, FLEN);
    check_outs("frameC", 10'h001, 10'h002, 10'h003, 10'h004, 7'h2A, 8'h80, 1'b1, 1'b1, 8'd1);

    // Broken preamble while locked
    send_byte(8'hFF); send_byte(8'hFF); send_byte(8'hFE);
    check_outs("pre_bad", 10'h001, 10'h002, 10'h003, 10'h004, 7'h2A, 8'h80, 1'b0, 1'b0, 8'd2);
    load_frame(10'h3FE, 10'h100, 10'h0F0, 10'h00F, 7'h40, 8'h07);
    send_pre(); send_frm(0, FLEN);
    check_outs("frameD", 10'h3FE, 10'h100, 10'h0F0, 10'h00F, 7'h40, 8'h07, 1'b1, 1'b1, 8'd2);

    // Partial frame then idle past the timeout
    load_frame(10'h111, 10'h222, 10'h333, 10'h044, 7'h55, 8'h66);
    send_pre(); send_frm(0, 5);
    check("partial.lock", 32'(sync_locked), 32'd1);
    repeat (TMO + 5) @(negedge clk);
    check_outs("timeout", 10'h3FE, 10'h100, 10'h0F0, 10'h00F, 7'h40, 8'h07, 1'b0, 1'b0, 8'd3);

    // Reset mid-frame
    send_pre(); send_frm(0, 3);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_outs("rst_mid", 10'h0, 10'h0, 10'h0, 10'h0, 7'h0, 8'h0, 1'b0, 1'b0, 8'd0);

    // Five 0xFF in hunt: the fifth is payload byte 0
    load_frame(10'h0FF, 10'h123, 10'h045, 10'h067, 7'h1B, 8'h99);
    send_pre(); send_frm(0, FLEN);
    check_outs("frameE", 10'h0FF, 10'h123, 10'h045, 10'h067, 7'h1B, 8'h99, 1'b1, 1'b1, 8'd0);

    // Error counter saturation
    for (int i = 0; i < 255; i++) begin
      send_pre(); send_byte(8'h00); send_byte(8'h04);
    end
    check("sat.err255", 32'(err_count), 32'd255);
    for (int i = 0; i < 5; i++) begin
      send_pre(); send_byte(8'h00); send_byte(8'h04);
    end
    check_outs("sat", 10'h0FF, 10'h123, 10'h045, 10'h067, 7'h1B, 8'h99, 1'b0, 1'b0, 8'd255);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rxd_frame_decoder.md
Name: rxd_frame_decoder

Overview:
Receive-side counterpart of the 14-byte UART telemetry frame that each board sends to its peer.
- Input is a byte stream from the UART receiver (one-cycle rx_done strobe per byte).
- The block finds the 0xFF sync preamble, collects the 10 payload bytes, and range-checks them.
- Enemy tank/bullet/status registers are updated atomically, once per good frame, for the game logic.
- Lock, frame-valid and error status are exported for debug/LEDs.

Parameters:
SYNC_LEN, 4, number of consecutive 0xFF bytes forming the preamble
PAYLOAD_LEN, 10, payload bytes per frame (fixed layout below; not meant to be changed)
TIMEOUT_CYCLES, 100000, max clk cycles between bytes inside a frame before abort (~1 ms at 100 MHz)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
rx_data  in  8  received byte, valid when rx_done=1
rx_done  in  1  one-cycle strobe, byte available
xpos_tank_enemy  out  10  enemy tank X
ypos_tank_enemy  out  10  enemy tank Y
xpos_bullet_enemy  out  10  enemy bullet X
ypos_bullet_enemy  out  10  enemy bullet Y
flags_enemy  out  7  {select_mode, direction_tank[1:0], direction_for_enemy[2:0], tank_hit}
hp_enemy  out  8  enemy HP
frame_valid  out  1  one-cycle pulse, all outputs just updated
sync_locked  out  1  1 while decoder is frame-aligned
err_count  out  8  saturating count of rejected frames/timeouts

Behaviour:
- Reset: all outputs 0; state HUNT; internal counters and shadow registers 0.
- Frame byte order:
  - 0 X[7:0]; 1 {6'b0,X[9:8]}
  - 2 Y lo; 3 Y hi
  - 4 bulletX lo; 5 bulletX hi
  - 6 bulletY lo; 7 bulletY hi
  - 8 {1'b0,flags[6:0]}
  - 9 HP
- All byte processing happens on the clk edge where rx_done=1. rx_data is ignored when rx_done=0.
- HUNT:
  - sync_cnt counts consecutive 0xFF bytes, saturating at SYNC_LEN. Any other byte clears it to 0.
  - When sync_cnt == SYNC_LEN and a byte arrives, that byte is payload byte 0 (even if it is 0xFF). Go to PAYLOAD, idx=1.
- PAYLOAD:
  - Store the byte into the shadow register at idx; idx++.
  - Range check: hi bytes (idx 1,3,5,7) must be <= 0x03; byte 8 bit7 must be 0.
  - Violation: err_count++ (saturate 255), sync_locked=0, go to HUNT with sync_cnt=0. Outputs are not updated.
  - After byte 9 is accepted, on that same edge: all outputs load from the shadow registers plus byte 9, frame_valid=1 for exactly one cycle, sync_locked=1, go to SYNC_CHECK with cnt=0.
  - Output latency is 1 cycle after the HP byte's rx_done.
- SYNC_CHECK (locked):
  - Expect SYNC_LEN bytes of 0xFF; cnt++ on each.
  - After the SYNC_LEN-th 0xFF, go to PAYLOAD with idx=0.
  - Any non-0xFF byte: err_count++, sync_locked=0, go to HUNT with sync_cnt=0.
  - The first byte after the preamble is always payload; this resolves HP=0xFF followed by the preamble.
- Timeout:
  - A counter clears on every rx_done and otherwise increments, saturating.
  - In PAYLOAD or SYNC_CHECK, reaching TIMEOUT_CYCLES forces HUNT, sync_locked=0, err_count++.
  - In HUNT, a timeout clears sync_cnt only; no error counted.
  - If rx_done and the timeout occur in the same cycle, rx_done wins and no timeout is taken.
- Outputs hold their last good frame indefinitely. They are never partially updated.
- Reset mid-frame discards the partial frame; outputs return to 0.

Optional Feature:
RXD_FRAME_CHECKSUM_EN:
- Defined: the frame carries an 11th payload byte equal to the XOR of payload bytes 0..9.
  - Mismatch is treated as a range violation: no update, err_count++, HUNT.
  - frame_valid fires one cycle after the checksum byte's rx_done.
- Undefined: frame is exactly 10 payload bytes with no checksum, as described above.

Test Plan:
- Reset, then send FF FF FF FF, 2C 01, 64 00, 10 02, 20 03, 55, C8 → one cycle after the last rx_done:
  - X=0x12C, Y=0x064, bulletX=0x210, bulletY=0x320, flags=0x55, hp=0xC8
  - frame_valid pulses once; sync_locked=1; err_count=0.
- Two back-to-back frames, the first with HP=0xFF and the second with X lo=0xFF → both decode correctly, with no loss of lock.
- Locked, then byte 1 (X hi) = 0x04 → no output change, err_count=1, sync_locked=0. The next clean frame decodes normally.
- Locked, then the third preamble byte = 0xFE → err_count increments, HUNT. Outputs keep the previous frame.
- Send the preamble plus 5 payload bytes, then idle TIMEOUT_CYCLES+5 cycles → sync_locked=0, err_count+1, outputs unchanged. Assert rst mid-frame → all outputs 0.
- Force 260 bad frames → err_count saturates at 255.
